// File: rtl/priority_grant_decoder_pkg.sv
// Shared constants for the priority code link between the 4-line encoder and
// the grant decoder: code field positions, the "no request" code and FSM states.
package priority_grant_decoder_pkg;

  localparam int         VALID_BIT = 2;
  localparam int         IDX_MSB   = 1;
  localparam int         IDX_LSB   = 0;
  localparam logic [2:0] CODE_NONE = 3'b000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_e;

  // Wait counter width: enough to hold TIMEOUT, never narrower than one bit.
  function automatic int wait_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/priority_grant_decoder_if.sv
// Request/grant bundle between the encoder/service side (master) and the
// grant decoder (slave). hit_cnt exists only when DECODE_COUNT_EN is defined.
interface priority_grant_decoder_if
`ifdef DECODE_COUNT_EN
  #(parameter int CNT_W = 8)
`endif
  ;
  logic       enable;
  logic [2:0] code;
  logic       ack;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       busy;
  logic       done;
  logic       timeout;
  logic       code_err;
`ifdef DECODE_COUNT_EN
  logic [4*CNT_W-1:0] hit_cnt;
`endif

  modport master (
    output enable, code, ack,
    input  grant, grant_idx, busy, done, timeout, code_err
`ifdef DECODE_COUNT_EN
    , input hit_cnt
`endif
  );

  modport slave (
    input  enable, code, ack,
    output grant, grant_idx, busy, done, timeout, code_err
`ifdef DECODE_COUNT_EN
    , output hit_cnt
`endif
  );

endinterface

// File: rtl/priority_grant_decoder_onehot_dec2to4.sv
// 2-to-4 one-hot decoder with enable; all zeros when disabled.
module onehot_dec2to4 (
  input  logic       en_i,
  input  logic [1:0] idx_i,
  output logic [3:0] onehot_o
);

  // Shift a single set bit into position; the enable gates the whole word.
  always_comb begin
    onehot_o = 4'b0000;
    if (en_i) onehot_o = 4'b0001 << idx_i;
  end

endmodule

// File: rtl/priority_grant_decoder.sv
// Priority grant decoder: registers the encoder code, holds a one-hot grant
// until ack, abort or timeout, then waits for the request to drop.
// Optional per-line completion counters are built when DECODE_COUNT_EN is defined.
module priority_grant_decoder
  import priority_grant_decoder_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input logic                    clk,
  input logic                    rst_n,
  priority_grant_decoder_if.slave bus
);

  localparam int             WCW       = wait_width(TIMEOUT);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit             TO_EN     = (TIMEOUT > 0);

  // Reject nonsensical widths at elaboration.
  if (CNT_W < 1) begin : g_cnt_w_check
    $error("CNT_W must be at least 1");
  end

  state_e         state_q;
  logic [3:0]     grant_q;
  logic [1:0]     idx_q;
  logic           busy_q;
  logic           done_q;
  logic           timeout_q;
  logic           code_err_q;
  logic [WCW-1:0] wait_q;
  logic [3:0]     dec_onehot;
  logic           ack_evt;

  onehot_dec2to4 u_dec (
    .en_i     (bus.code[VALID_BIT]),
    .idx_i    (bus.code[IDX_MSB:IDX_LSB]),
    .onehot_o (dec_onehot)
  );

  // An ack in GRANT completes the grant regardless of enable or timeout.
  assign ack_evt = (state_q == GRANT) && bus.ack;

  // Grant FSM with registered outputs; pulses default low every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_q    <= 4'b0000;
      idx_q      <= 2'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      code_err_q <= 1'b0;
      wait_q     <= '0;
    end else begin
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      code_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.enable) begin
            if (bus.code[VALID_BIT]) begin
              grant_q <= dec_onehot;
              idx_q   <= bus.code[IDX_MSB:IDX_LSB];
              wait_q  <= '0;
              busy_q  <= 1'b1;
              state_q <= GRANT;
            end else if (bus.code != CODE_NONE) begin
              code_err_q <= 1'b1;
            end
          end
        end
        GRANT: begin
          if (bus.ack) begin
            grant_q <= 4'b0000;
            done_q  <= 1'b1;
            state_q <= RELEASE;
          end else if (!bus.enable) begin
            grant_q <= 4'b0000;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (TO_EN && (wait_q == WAIT_LAST)) begin
            grant_q   <= 4'b0000;
            timeout_q <= 1'b1;
            state_q   <= RELEASE;
          end else if (TO_EN) begin
            wait_q <= wait_q + 1'b1;
          end
        end
        RELEASE: begin
          // The request must drop before another grant can be issued.
          if (!bus.code[VALID_BIT] || !bus.enable) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          grant_q <= 4'b0000;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.grant     = grant_q;
  assign bus.grant_idx = idx_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.timeout   = timeout_q;
  assign bus.code_err  = code_err_q;

`ifdef DECODE_COUNT_EN
  logic [3:0][CNT_W-1:0] cnt_q;

  // Per-line completion counters, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (ack_evt && (cnt_q[idx_q] != {CNT_W{1'b1}})) begin
      cnt_q[idx_q] <= cnt_q[idx_q] + 1'b1;
    end
  end

  assign bus.hit_cnt = cnt_q;
`else
  logic unused_ack_evt;
  assign unused_ack_evt = ack_evt;
`endif

endmodule
